// File: rtl/stack_arbiter.sv
// Round-robin arbiter/sequencer for two push/pop requesters sharing one LIFO stack.
// Handshake: reqN stays high with opN/dinN stable until a one-cycle ackN; rsp_* are valid in that ack cycle.
module stack_arbiter #(
   parameter int W     = 8,
   parameter int REJ_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic             op0,
   input  logic             op1,
   input  logic [W-1:0]     din0,
   input  logic [W-1:0]     din1,
   output logic             ack0,
   output logic             ack1,
   output logic [W-1:0]     rsp_data,
   output logic             rsp_err,
   output logic             gnt_id,
   output logic             busy,
   output logic [REJ_W-1:0] rej_cnt,
   output logic             stk_pushpop,
   output logic             stk_en,
   output logic [W-1:0]     stk_in,
   input  logic [W-1:0]     stk_out,
   input  logic             stk_empty,
   input  logic             stk_full,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, ACK = 2'd3} state_t;

   state_t           state, state_nxt;
   logic             last, last_d;
   logic             op_q, op_d;
   logic             sel, sel_op, start, illegal;
   logic [W-1:0]     sel_din;
   logic             ack0_d, ack1_d, rsp_err_d, gnt_d, busy_d, pp_d, en_d;
   logic [W-1:0]     rsp_data_d, stk_in_d;
   logic [REJ_W-1:0] rej_d;

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last        <= 1'b1;
         op_q        <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         gnt_id      <= 1'b0;
         busy        <= 1'b0;
         rej_cnt     <= '0;
         stk_pushpop <= 1'b0;
         stk_en      <= 1'b0;
         stk_in      <= '0;
      end else begin
         state       <= state_nxt;
         last        <= last_d;
         op_q        <= op_d;
         ack0        <= ack0_d;
         ack1        <= ack1_d;
         rsp_data    <= rsp_data_d;
         rsp_err     <= rsp_err_d;
         gnt_id      <= gnt_d;
         busy        <= busy_d;
         rej_cnt     <= rej_d;
         stk_pushpop <= pp_d;
         stk_en      <= en_d;
         stk_in      <= stk_in_d;
      end
   end

   // On contention the requester that was not served last wins.
   always_comb begin
      start   = req0 | req1;
      sel     = (req0 && req1) ? ~last : req1;
      sel_op  = sel ? op1 : op0;
      sel_din = sel ? din1 : din0;
      illegal = sel_op ? stk_empty : stk_full;
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = illegal ? ACK : ISSUE;
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for the registered outputs; the stack is only touched for legal ops.
   always_comb begin
      last_d     = last;
      op_d       = op_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      rsp_data_d = rsp_data;
      rsp_err_d  = rsp_err;
      gnt_d      = gnt_id;
      rej_d      = rej_cnt;
      pp_d       = stk_pushpop;
      en_d       = 1'b0;
      stk_in_d   = stk_in;
      busy_d     = (state_nxt != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               gnt_d = sel;
               op_d  = sel_op;
               if (illegal) begin
                  rsp_err_d = 1'b1;
                  ack0_d    = ~sel;
                  ack1_d    = sel;
                  rej_d     = (&rej_cnt) ? rej_cnt : rej_cnt + 1'b1;
               end else begin
                  en_d     = 1'b1;
                  pp_d     = sel_op;
                  stk_in_d = sel_din;
               end
            end
         end
         CAPTURE: begin
            if (op_q) rsp_data_d = stk_out;
            ack0_d = ~gnt_id;
            ack1_d = gnt_id;
         end
         ACK: begin
            last_d    = gnt_id;
            rsp_err_d = 1'b0;
         end
         default: ;
      endcase
   end

endmodule
